// File: rtl/cal_eep_spi_slave.sv
// SPI mode-0 slave in front of a 64x8 calibration EEPROM model; 16-bit frames {op[1:0], addr[5:0], data[7:0]}.
// Define CAL_EEP_WRT_LOCK_EN to make addresses 6'h30-6'h3F read-only.
module cal_eep_spi_slave (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic SCLK,
  input  logic MOSI,
  output logic MISO,
  output logic frame_done,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t      state_r, state_nxt_s;
  logic        ss_meta_r, ss_sync_r, ss_d_r;
  logic        sclk_meta_r, sclk_sync_r, sclk_d_r;
  logic        mosi_meta_r, mosi_sync_r, mosi_d_r;
  logic [4:0]  count_r;
  logic        overflow_r;
  logic [15:0] rx_shft_r, tx_shft_r, tx_nxt_s;
  logic [7:0]  rd_data_r;
  logic        miso_r, frame_done_r, busy_r;
  logic        ss_fall_s, ss_rise_s, sclk_rise_s, sclk_fall_s;
  logic        wr_en_s, rd_en_s, wr_allow_s;
  logic [7:0]  mem_r [0:63];

  assign ss_fall_s   = ss_d_r & ~ss_sync_r;
  assign ss_rise_s   = ~ss_d_r & ss_sync_r;
  // SCLK edges only count while the slave is selected
  assign sclk_rise_s = ~ss_sync_r & ~sclk_d_r & sclk_sync_r;
  assign sclk_fall_s = ~ss_sync_r & sclk_d_r & ~sclk_sync_r;

  // Synchronizers and edge-detect flops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ss_meta_r   <= 1'b1;
      ss_sync_r   <= 1'b1;
      ss_d_r      <= 1'b1;
      sclk_meta_r <= 1'b0;
      sclk_sync_r <= 1'b0;
      sclk_d_r    <= 1'b0;
      mosi_meta_r <= 1'b0;
      mosi_sync_r <= 1'b0;
      mosi_d_r    <= 1'b0;
    end else begin
      ss_meta_r   <= SS_n;
      ss_sync_r   <= ss_meta_r;
      ss_d_r      <= ss_sync_r;
      sclk_meta_r <= SCLK;
      sclk_sync_r <= sclk_meta_r;
      sclk_d_r    <= sclk_sync_r;
      mosi_meta_r <= MOSI;
      mosi_sync_r <= mosi_meta_r;
      mosi_d_r    <= mosi_sync_r;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a frame commits only with exactly 16 SCLK rises
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (ss_fall_s) state_nxt_s = ACTIVE;
        else           state_nxt_s = IDLE;
      end
      ACTIVE: begin
        if (ss_rise_s) begin
          if ((count_r == 5'd16) && !overflow_r) state_nxt_s = COMMIT;
          else                                    state_nxt_s = IDLE;
        end else begin
          state_nxt_s = ACTIVE;
        end
      end
      COMMIT:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Commit-cycle decode of the received frame
  always_comb begin
    wr_en_s    = 1'b0;
    rd_en_s    = 1'b0;
`ifdef CAL_EEP_WRT_LOCK_EN
    wr_allow_s = (rx_shft_r[13:12] != 2'b11);
`else
    wr_allow_s = 1'b1;
`endif
    if (state_r == COMMIT) begin
      case (rx_shft_r[15:14])
        2'b01:   wr_en_s = wr_allow_s;
        2'b00:   rd_en_s = 1'b1;
        default: begin
          wr_en_s = 1'b0;
          rd_en_s = 1'b0;
        end
      endcase
    end else begin
      wr_en_s = 1'b0;
      rd_en_s = 1'b0;
    end
  end

  // Transmit shifter next value
  always_comb begin
    tx_nxt_s = tx_shft_r;
    if (ss_fall_s) begin
      tx_nxt_s = {8'h00, rd_data_r};
    end else if (sclk_fall_s && (state_r == ACTIVE)) begin
      tx_nxt_s = {tx_shft_r[14:0], 1'b0};
    end else begin
      tx_nxt_s = tx_shft_r;
    end
  end

  // Datapath: bit counter, shifters, read latch and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r      <= 5'd0;
      overflow_r   <= 1'b0;
      rx_shft_r    <= 16'h0000;
      tx_shft_r    <= 16'h0000;
      rd_data_r    <= 8'h00;
      miso_r       <= 1'b0;
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      if (ss_fall_s) begin
        count_r    <= 5'd0;
        overflow_r <= 1'b0;
      end else if (sclk_rise_s && (state_r == ACTIVE)) begin
        rx_shft_r <= {rx_shft_r[14:0], mosi_d_r};
        if (count_r == 5'd16) overflow_r <= 1'b1;
        else                  count_r    <= count_r + 5'd1;
      end
      tx_shft_r    <= tx_nxt_s;
      if (rd_en_s) rd_data_r <= mem_r[rx_shft_r[13:8]];
      miso_r       <= ~ss_sync_r & tx_nxt_s[15];
      frame_done_r <= (state_nxt_s == COMMIT);
      busy_r       <= (state_nxt_s == ACTIVE);
    end
  end

  // Non-volatile storage: deliberately untouched by reset
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_r[rx_shft_r[13:8]] <= rx_shft_r[7:0];
  end

  assign MISO       = miso_r;
  assign frame_done = frame_done_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_cal_eep_spi_slave.sv
// Randomized self-checking bench for cal_eep_spi_slave; the reference model tracks
// memory contents and the pending read byte frame by frame.
module tb_cal_eep_spi_slave;

  logic clk = 1'b0;
  logic rst_n, SS_n, SCLK, MOSI;
  logic MISO, frame_done, busy;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  bit busy_seen;

`ifdef CAL_EEP_WRT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic [7:0] m_mem [64];
  bit         m_known [64];
  logic [7:0] m_rd;
  bit         m_rd_known;

  cal_eep_spi_slave dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
    .MISO(MISO), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: a frame takes effect only with exactly 16 bits; the byte shifted
  // out is whatever the last committed read fetched.
  task automatic model_frame(input logic [15:0] f, input int nbits,
                             output logic [15:0] exp, output bit valid);
    int a;
    exp   = {8'h00, m_rd};
    valid = m_rd_known;
    a     = int'(f[13:8]);
    if (nbits == 16) begin
      if (f[15:14] == 2'b01 && !(LOCK && a >= 48)) begin
        m_mem[a]   = f[7:0];
        m_known[a] = 1'b1;
      end else if (f[15:14] == 2'b00) begin
        m_rd       = m_mem[a];
        m_rd_known = m_known[a];
      end
    end
  endtask

  task automatic spi_frame(input logic [15:0] f, input int nbits, input int h,
                           input bit finish, output logic [15:0] got);
    got   = 16'h0000;
    SS_n  = 1'b0;
    MOSI  = f[15];
    wait_clk(h);
    busy_seen = (busy === 1'b1);
    for (int i = 0; i < nbits; i++) begin
      int k;
      if (i < 16) got[15-i] = MISO;
      SCLK = 1'b1;
      wait_clk(h);
      SCLK = 1'b0;
      k = 14 - i;
      if (k >= 0) MOSI = f[k];
      else        MOSI = 1'($urandom);
      wait_clk(h);
    end
    if (finish) begin
      SS_n = 1'b1;
      wait_clk(2 * h + 4);
    end
  endtask

  task automatic run_frame(input logic [15:0] f, input int nbits, input int h,
                           output logic [15:0] got, output logic [15:0] exp,
                           output bit valid, output int dones);
    int d0;
    d0 = done_cnt;
    model_frame(f, nbits, exp, valid);
    spi_frame(f, nbits, h, 1'b1, got);
    dones = done_cnt - d0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    wait_clk(4);
    rst_n = 1'b1;
    wait_clk(2);
    m_rd = 8'h00; m_rd_known = 1'b1;
    for (int i = 0; i < 64; i++) m_known[i] = 1'b0;
    checks++; if (MISO !== 1'b0) begin errors++; $display("FAIL reset_miso got %b want 0", MISO); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", frame_done); end
  endtask

  task automatic test_write_readback;
    logic [15:0] got, exp; bit v; int d, total;
    logic [15:0] frames [3];
    frames = '{16'h55A7, 16'h1500, 16'h0000};
    total = 0;
    for (int i = 0; i < 3; i++) begin
      run_frame(frames[i], 16, $urandom_range(4, 7), got, exp, v, d);
      total += d;
      if (v) begin
        checks++;
        if (got !== exp) begin errors++; $display("FAIL wr_rd_miso frame %0d got %h want %h", i, got, exp); end
      end
    end
    checks++; if (got !== 16'h00A7) begin errors++; $display("FAIL wr_rd_final got %h want 00a7", got); end
    checks++; if (total !== 3) begin errors++; $display("FAIL wr_rd_dones got %0d want 3", total); end
  endtask

  task automatic test_abort;
    logic [15:0] got, exp; bit v; int d;
    run_frame(16'h553C, 9, 5, got, exp, v, d);
    checks++; if (d !== 0) begin errors++; $display("FAIL abort9_done got %0d want 0", d); end
    checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL abort9_busy_mid got %b want 1", busy_seen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort9_busy_end got %b want 0", busy); end
    run_frame(16'h5511, 17, 4, got, exp, v, d);
    checks++; if (d !== 0) begin errors++; $display("FAIL abort17_done got %0d want 0", d); end
    run_frame(16'h1500, 16, 4, got, exp, v, d);
    run_frame(16'h0000, 16, 4, got, exp, v, d);
    checks++; if (got !== exp || got !== 16'h00A7) begin errors++; $display("FAIL abort_mem got %h want 00a7", got); end
  endtask

  task automatic test_reset_midframe;
    logic [15:0] got, exp; bit v; int d, d0;
    run_frame(16'h425A, 16, 5, got, exp, v, d);
    spi_frame(16'h4211, 8, 5, 1'b0, got);
    rst_n = 1'b0;
    wait_clk(2);
    SS_n = 1'b1; SCLK = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(4);
    m_rd = 8'h00; m_rd_known = 1'b1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
    d0 = done_cnt;
    run_frame(16'h0200, 16, 5, got, exp, v, d);
    checks++; if (got !== 16'h0000) begin errors++; $display("FAIL rstmid_first got %h want 0000", got); end
    run_frame(16'h0000, 16, 5, got, exp, v, d);
    checks++; if (got !== exp || got !== 16'h005A) begin errors++; $display("FAIL rstmid_read got %h want 005a", got); end
    checks++; if (done_cnt - d0 !== 2) begin errors++; $display("FAIL rstmid_dones got %0d want 2", done_cnt - d0); end
  endtask

  task automatic test_reserved;
    logic [15:0] got, exp; bit v; int d;
    run_frame(16'h4011, 16, 4, got, exp, v, d);
    run_frame(16'h1500, 16, 4, got, exp, v, d);
    run_frame(16'hC0FF, 16, 4, got, exp, v, d);
    checks++; if (d !== 1) begin errors++; $display("FAIL rsvd_done got %0d want 1", d); end
    run_frame(16'h0000, 16, 4, got, exp, v, d);
    checks++; if (got !== exp || got !== 16'h00A7) begin errors++; $display("FAIL rsvd_rd got %h want 00a7", got); end
    run_frame(16'h0000, 16, 4, got, exp, v, d);
    checks++; if (got !== exp || got !== 16'h0011) begin errors++; $display("FAIL rsvd_mem got %h want 0011", got); end
  endtask

  task automatic test_write_lock;
    logic [15:0] got, exp; bit v; int d, total;
    total = 0;
    run_frame(16'h7099, 16, 4, got, exp, v, d); total += d;
    run_frame(16'h3000, 16, 4, got, exp, v, d); total += d;
    run_frame(16'h0000, 16, 4, got, exp, v, d); total += d;
    checks++; if (total !== 3) begin errors++; $display("FAIL lock_dones got %0d want 3", total); end
    if (v) begin
      checks++; if (got !== exp) begin errors++; $display("FAIL lock_read got %h want %h", got, exp); end
    end
  endtask

  task automatic test_min_timing;
    logic [15:0] got, exp; bit v; int d;
    for (int a = 0; a < 64; a++)
      run_frame({2'b01, 6'(a), 8'($urandom)}, 16, 4, got, exp, v, d);
    for (int a = 0; a <= 64; a++) begin
      run_frame({2'b00, 6'(a % 64), 8'($urandom)}, 16, 4, got, exp, v, d);
      if (v) begin
        checks++;
        if (got !== exp) begin errors++; $display("FAIL sweep_read addr %0d got %h want %h", a - 1, got, exp); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_abort();
    test_reset_midframe();
    test_reserved();
    test_write_lock();
    test_min_timing();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
